clk_ratio_monitor: RTL and testbench
====================================

Name: clk_ratio_monitor

Overview:
- Measures a slow, divided clock (`sig_in`) against the fast reference clock `clkin`.
- Reports the period and high time of `sig_in` in `clkin` cycles.
- Declares lock when the measured period matches the expected divide ratio; flags mismatch and loss-of-clock.
- Sits at the consuming end of the clock-divider chain, as a self-check or monitor block.

Parameters:
- EXPECT_PERIOD, 9, expected `sig_in` period in `clkin` cycles (valid range 2 to MAX_PERIOD).
- LOCK_COUNT, 4, consecutive matching periods required to assert lock (1 to 15).
- MAX_PERIOD, 255, cycles without a `sig_in` rising edge before timeout. CNT_W = $clog2(MAX_PERIOD+1), derived internally.

Ports:
- clkin  input  1  reference clock, all logic on posedge
- rst  input  1  asynchronous active-low reset
- sig_in  input  1  monitored clock, asynchronous to `clkin`
- period_out  output  CNT_W  last measured period in `clkin` cycles
- high_out  output  CNT_W  last measured high time in `clkin` cycles
- meas_valid  output  1  one-cycle pulse when `period_out`/`high_out` update
- lock  output  1  period stable at EXPECT_PERIOD
- mismatch  output  1  one-cycle pulse, measured period != EXPECT_PERIOD
- timeout  output  1  one-cycle pulse, no rising edge for MAX_PERIOD cycles

Behaviour:
- Reset (`rst` low, asynchronous): all outputs 0; counters 0; match count 0; state IDLE.
- Synchronizer: `sig_in` → s1 → s2 (2 flops), then s3 <= s2.
  - rise = s2 & ~s3.
  - An edge on `sig_in` produces `rise` 3 `clkin` edges later.
- Counters, cnt and hcnt:
  - Width CNT_W; saturate at MAX_PERIOD and never wrap.
  - cnt increments every cycle.
  - hcnt increments in cycles where s2 = 1.
- State IDLE:
  - Counters held at 0; outputs unchanged except the pulse outputs, which are 0.
  - On `rise`: cnt <= 1, hcnt <= 1, go to MEASURE. No measurement is emitted on this first edge (partial period).
- State MEASURE, on `rise`:
  - Register the measurement: `period_out` <= cnt, `high_out` <= hcnt.
  - `meas_valid` <= 1 for one cycle.
  - Restart counting: cnt <= 1, hcnt <= 1.
  - If cnt == EXPECT_PERIOD: match count increments, saturating at LOCK_COUNT.
  - Otherwise: match count <= 0, `mismatch` pulse, `lock` <= 0.
  - `lock` <= 1 in the cycle the match count reaches LOCK_COUNT; it stays high while matches continue.
- State MEASURE, no `rise`:
  - If cnt == MAX_PERIOD: `timeout` pulse, `lock` <= 0, match count <= 0, go to IDLE.
  - `period_out`/`high_out` keep their last values.
- Simultaneous rise and cnt == MAX_PERIOD: the rise wins; a normal measurement is taken and there is no timeout.
- Registration: all outputs are registered. `meas_valid`, `mismatch` and `lock` update on the same edge.
- Constant level on `sig_in` (stuck high or low): timeout after MAX_PERIOD cycles, then remain in IDLE.
  - `high_out` is not updated on timeout.
- Reset mid-measurement: immediate return to reset values; the first post-reset rise is again discarded.

Decomposition:
- Package `clk_mon_pkg`:
  - state enum `mon_state_t` {IDLE, MEASURE}.
  - function for CNT_W derivation.
- Sub-module `sync_edge_det`:
  - 2-flop synchronizer plus delay flop.
  - Outputs `lvl` (s2) and `rise`.
  - `clkin`/`rst` only; reusable across the codebase.

Test Plan:
- 1. Divide-by-9 reference: drive `sig_in` with period 9 `clkin` cycles, high 4.
  - Expect `meas_valid` every 9 cycles, `period_out` = 9, `high_out` = 4.
  - `lock` rises at the 4th measurement (5th rise).
- 2. Divide-by-4, 50% duty, with EXPECT_PERIOD = 9.
  - Expect `period_out` = 4, `high_out` = 2.
  - `mismatch` pulses on every measurement; `lock` stays 0.
- 3. Locked at 9, then one period of 10.
  - Expect `mismatch` pulse and `lock` falling on that measurement.
  - `lock` re-asserts after 4 further periods of 9.
- 4. Locked, then `sig_in` held low (MAX_PERIOD = 255).
  - Expect `timeout` pulse exactly 255 cycles after the last rise; `lock` = 0.
  - Next rise produces no `meas_valid`; the following rise does.
- 5. Assert `rst` low mid-period while locked.
  - All outputs 0 asynchronously.
  - After release, the first rise is discarded and lock needs 4 fresh matches.
- 6. Boundary: EXPECT_PERIOD = 2, `sig_in` toggling every `clkin` cycle through the synchronizer.
  - `period_out` = 2, `high_out` = 1, `lock` after 4 matches.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the clock-ratio monitor.
//   mon_state_t : measurement state machine encoding
//   MATCH_W     : width of the consecutive-match counter (LOCK_COUNT <= 15)
//   cnt_width() : counter width able to hold 0..max_period
package clk_mon_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } mon_state_t;

  localparam int unsigned MATCH_W = 4;

  function automatic int unsigned cnt_width(input int unsigned max_period);
    return $clog2(max_period + 1);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a delay flop for rising-edge detection.
//   clkin  : sampling clock
//   rst    : asynchronous active-low reset
//   sig_in : asynchronous input
//   lvl    : synchronized level (second synchronizer flop)
//   rise   : one-cycle pulse on a synchronized rising edge
module sync_edge_det (
  input  logic clkin,
  input  logic rst,
  input  logic sig_in,
  output logic lvl,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // s1/s2 resolve metastability; s3 is the previous synchronized level
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures period and high time of a divided clock in reference-clock cycles,
// declares lock after LOCK_COUNT consecutive periods equal to EXPECT_PERIOD,
// and flags mismatching periods and loss of clock.
//   clkin      : reference clock
//   rst        : asynchronous active-low reset
//   sig_in     : monitored clock (asynchronous)
//   period_out : last measured period
//   high_out   : last measured high time
//   meas_valid : pulse when period_out/high_out update
//   lock       : period stable at EXPECT_PERIOD
//   mismatch   : pulse when a measured period differs from EXPECT_PERIOD
//   timeout    : pulse when no rising edge was seen for MAX_PERIOD cycles
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter  int unsigned EXPECT_PERIOD = 9,
  parameter  int unsigned LOCK_COUNT    = 4,
  parameter  int unsigned MAX_PERIOD    = 255,
  localparam int unsigned CNT_W         = cnt_width(MAX_PERIOD)
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             lock,
  output logic             mismatch,
  output logic             timeout
);

  localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]   EXP_CNT  = CNT_W'(EXPECT_PERIOD);
  localparam logic [CNT_W-1:0]   ONE_CNT  = CNT_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_CNT = MATCH_W'(LOCK_COUNT);

  logic lvl;
  logic rise;

  mon_state_t           state_q,      state_d;
  logic [CNT_W-1:0]     cnt_q,        cnt_d;
  logic [CNT_W-1:0]     hcnt_q,       hcnt_d;
  logic [MATCH_W-1:0]   match_q,      match_d;
  logic [MATCH_W-1:0]   match_inc;
  logic [CNT_W-1:0]     period_q,     period_d;
  logic [CNT_W-1:0]     high_q,       high_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 lock_q,       lock_d;
  logic                 mismatch_q,   mismatch_d;
  logic                 timeout_q,    timeout_d;

  sync_edge_det u_sync (
    .clkin  (clkin),
    .rst    (rst),
    .sig_in (sig_in),
    .lvl    (lvl),
    .rise   (rise)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX_CNT) ? v : v + ONE_CNT;
  endfunction

  // Match counter saturates so lock holds through an arbitrarily long run
  assign match_inc = (match_q == LOCK_CNT) ? match_q : match_q + MATCH_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hcnt_d       = hcnt_q;
    match_d      = match_q;
    period_d     = period_q;
    high_d       = high_q;
    lock_d       = lock_q;
    meas_valid_d = 1'b0;
    mismatch_d   = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        hcnt_d = '0;
        // First edge only starts the count; the preceding period is partial
        if (rise) begin
          cnt_d   = ONE_CNT;
          hcnt_d  = ONE_CNT;
          state_d = MEASURE;
        end
      end

      MEASURE: begin
        // A rise takes priority over a coincident timeout
        if (rise) begin
          period_d     = cnt_q;
          high_d       = hcnt_q;
          meas_valid_d = 1'b1;
          cnt_d        = ONE_CNT;
          hcnt_d       = ONE_CNT;
          if (cnt_q == EXP_CNT) begin
            match_d = match_inc;
            lock_d  = (match_inc == LOCK_CNT);
          end else begin
            match_d    = '0;
            mismatch_d = 1'b1;
            lock_d     = 1'b0;
          end
        end else if (cnt_q == MAX_CNT) begin
          timeout_d = 1'b1;
          lock_d    = 1'b0;
          match_d   = '0;
          cnt_d     = '0;
          hcnt_d    = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
          if (lvl) begin
            hcnt_d = sat_inc(hcnt_q);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      match_q      <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      lock_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      match_q      <= match_d;
      period_q     <= period_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      lock_q       <= lock_d;
      mismatch_q   <= mismatch_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period_out = period_q;
  assign high_out   = high_q;
  assign meas_valid = meas_valid_q;
  assign lock       = lock_q;
  assign mismatch   = mismatch_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Self-checking bench: two monitors (expected period 9 and 2) watch the same
// stimulus; a reference model derives expected outputs from the times of
// rising edges and the high samples of the driven waveform.
module tb_clk_ratio_monitor;

  localparam int LOCK_N = 4;
  localparam int MAXP   = 255;
  localparam int HIST_N = 65536;

  logic       clkin = 1'b0;
  logic       rst   = 1'b0;
  logic       sig_in = 1'b0;

  logic [7:0] per9, hi9, per2, hi2;
  logic       mv9, lk9, mm9, to9;
  logic       mv2, lk2, mm2, to2;

  clk_ratio_monitor #(.EXPECT_PERIOD(9), .LOCK_COUNT(LOCK_N), .MAX_PERIOD(MAXP)) u_dut9 (
    .clkin      (clkin),
    .rst        (rst),
    .sig_in     (sig_in),
    .period_out (per9),
    .high_out   (hi9),
    .meas_valid (mv9),
    .lock       (lk9),
    .mismatch   (mm9),
    .timeout    (to9)
  );

  clk_ratio_monitor #(.EXPECT_PERIOD(2), .LOCK_COUNT(LOCK_N), .MAX_PERIOD(MAXP)) u_dut2 (
    .clkin      (clkin),
    .rst        (rst),
    .sig_in     (sig_in),
    .period_out (per2),
    .high_out   (hi2),
    .meas_valid (mv2),
    .lock       (lk2),
    .mismatch   (mm2),
    .timeout    (to2)
  );

  always #5 clkin = ~clkin;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit hist [HIST_N];
  int edge_cnt   = 0;
  int valid_from = 0;

  int exp_p    [2] = '{9, 2};
  bit m_active [2];
  int m_last   [2];
  int m_hi     [2];
  int m_match  [2];
  int e_per    [2];
  int e_hi     [2];
  bit e_mv [2], e_lk [2], e_mm [2], e_to [2];

  // Value of sig_in seen at clock edge k (zero before reset release)
  function automatic bit samp(input int k);
    if (k < valid_from || k < 0) return 1'b0;
    return hist[k];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0; m_last[i] = 0; m_hi[i] = 0; m_match[i] = 0;
      e_per[i] = 0; e_hi[i] = 0;
      e_mv[i] = 1'b0; e_lk[i] = 1'b0; e_mm[i] = 1'b0; e_to[i] = 1'b0;
    end
  endtask

  // Edge seen at sample e-2 reaches the monitor's decision at edge e
  task automatic model_step(input int i, input int e);
    bit r;
    bit lv;
    lv = samp(e - 2);
    r  = lv && !samp(e - 3);
    e_mv[i] = 1'b0; e_mm[i] = 1'b0; e_to[i] = 1'b0;
    if (!m_active[i]) begin
      if (r) begin
        m_active[i] = 1'b1; m_last[i] = e; m_hi[i] = 1;
      end
    end else if (r) begin
      e_per[i] = e - m_last[i];
      e_hi[i]  = m_hi[i];
      e_mv[i]  = 1'b1;
      m_last[i] = e; m_hi[i] = 1;
      if (e_per[i] == exp_p[i]) begin
        m_match[i] = (m_match[i] + 1 > LOCK_N) ? LOCK_N : m_match[i] + 1;
        e_lk[i] = (m_match[i] == LOCK_N);
      end else begin
        m_match[i] = 0; e_mm[i] = 1'b1; e_lk[i] = 1'b0;
      end
    end else if (e - m_last[i] == MAXP) begin
      e_to[i] = 1'b1; e_lk[i] = 1'b0; m_match[i] = 0; m_active[i] = 1'b0;
    end else if (lv) begin
      m_hi[i] = (m_hi[i] + 1 > MAXP) ? MAXP : m_hi[i] + 1;
    end
  endtask

  task automatic compare_dut(input int i, input string nm,
                             input logic [7:0] per, input logic [7:0] hi,
                             input logic mv, input logic lk, input logic mm, input logic to);
    check_eq({nm, ".period_out"}, 32'(per), 32'(e_per[i]));
    check_eq({nm, ".high_out"},   32'(hi),  32'(e_hi[i]));
    check_eq({nm, ".meas_valid"}, 32'(mv),  32'(e_mv[i]));
    check_eq({nm, ".lock"},       32'(lk),  32'(e_lk[i]));
    check_eq({nm, ".mismatch"},   32'(mm),  32'(e_mm[i]));
    check_eq({nm, ".timeout"},    32'(to),  32'(e_to[i]));
  endtask

  // Per-edge model update, then compare just after the edge
  always begin
    @(posedge clkin);
    edge_cnt++;
    if (edge_cnt < HIST_N) hist[edge_cnt] = sig_in;
    if (!rst) begin
      valid_from = edge_cnt + 1;
      model_reset();
    end else begin
      model_step(0, edge_cnt);
      model_step(1, edge_cnt);
    end
    #1;
    compare_dut(0, "u_dut9", per9, hi9, mv9, lk9, mm9, to9);
    compare_dut(1, "u_dut2", per2, hi2, mv2, lk2, mm2, to2);
  end

  // ---------------- stimulus ----------------
  task automatic drive_wave(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clkin);
        sig_in = (c < h);
      end
    end
  endtask

  task automatic hold(input bit v, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clkin);
      sig_in = v;
    end
  endtask

  task automatic check_all_zero();
    check_eq("rst.u_dut9", {per9, hi9, mv9, lk9, mm9, to9}, 32'd0);
    check_eq("rst.u_dut2", {per2, hi2, mv2, lk2, mm2, to2}, 32'd0);
  endtask

  initial begin
    model_reset();
    rst = 1'b0; sig_in = 1'b0;
    repeat (3) @(negedge clkin);
    check_all_zero();
    rst = 1'b1;

    // divide-by-9, high 4: lock on the 4th measurement
    drive_wave(9, 4, 8);
    // divide-by-4 50%: mismatch every measurement
    drive_wave(4, 2, 6);
    // locked, one long period, relock
    drive_wave(9, 4, 6);
    drive_wave(10, 5, 1);
    drive_wave(9, 4, 6);
    // locked, then stuck low until timeout, then restart
    drive_wave(9, 4, 6);
    hold(1'b0, 300);
    drive_wave(9, 4, 3);
    // asynchronous reset mid-period while locked
    drive_wave(9, 4, 6);
    hold(1'b1, 3);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero();
    repeat (3) @(negedge clkin);
    rst = 1'b1;
    drive_wave(9, 4, 7);
    // fastest clock through the synchronizer
    drive_wave(2, 1, 10);
    // stuck high: timeout, high_out left alone
    hold(1'b1, 300);
    // period exactly MAX_PERIOD (rise wins) and one longer (timeout)
    drive_wave(255, 1, 3);
    drive_wave(256, 100, 3);

    // randomized segments
    for (int s = 0; s < 30; s++) begin
      int kind;
      int p;
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1, 2: begin
          p = int'($urandom_range(2, 20));
          drive_wave(p, int'($urandom_range(1, p - 1)), int'($urandom_range(1, 8)));
        end
        3:       drive_wave(9, int'($urandom_range(1, 8)), 6);
        4:       hold(1'($urandom_range(0, 1)), int'($urandom_range(200, 300)));
        default: drive_wave(2, 1, 6);
      endcase
    end

    hold(1'b0, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
